// File: rtl/cordic_iter_engine.sv
// Iterative fixed-point CORDIC engine (rotation / vectoring), one micro-rotation per clock.
// Optional macro CORDIC_GAIN_COMP_EN adds a SCALE state that removes the CORDIC gain from x/y.
//
//  state | meaning
//  IDLE  | waiting for an input handshake
//  ROT   | applying micro-rotation i = r_iter
//  SCALE | multiplying x/y by 1/K (only with CORDIC_GAIN_COMP_EN)
//  DONE  | result presented, waiting for out_ready
module cordic_iter_engine #(
  parameter int WIDTH      = 16,
  parameter int ITERATIONS = 14,
  parameter int GUARD_BITS = 3
) (
  input  logic             ap_clk,
  input  logic             ap_rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic             in_mode,
  input  logic [WIDTH-1:0] in_x,
  input  logic [WIDTH-1:0] in_y,
  input  logic [WIDTH-1:0] in_z,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_x,
  output logic [WIDTH-1:0] out_y,
  output logic [WIDTH-1:0] out_z,
  output logic             busy
);

  localparam int IW    = WIDTH + 1 + GUARD_BITS;
  localparam int FZ    = WIDTH - 3 + GUARD_BITS;
  localparam int SH_DN = (FZ <= 30) ? 30 - FZ : 0;
  localparam int SH_UP = (FZ > 30) ? FZ - 30 : 0;
  localparam int CW    = $clog2(ITERATIONS);
  localparam logic [CW-1:0] LAST = CW'(ITERATIONS - 1);

  typedef enum logic [1:0] {S_IDLE, S_ROT, S_SCALE, S_DONE} state_t;

  // atan(2^-i) in radians scaled by 2^30; beyond i=9 atan(2^-i) equals 2^-i to well below 1 LSB
  function automatic logic [63:0] atan_q30(input int i);
    case (i)
      0:       return 64'd843314857;
      1:       return 64'd497837829;
      2:       return 64'd263043837;
      3:       return 64'd133525159;
      4:       return 64'd67021687;
      5:       return 64'd33543516;
      6:       return 64'd16775851;
      7:       return 64'd8388437;
      8:       return 64'd4194283;
      9:       return 64'd2097149;
      default: return 64'd1 << (30 - i);
    endcase
  endfunction

  function automatic logic signed [IW-1:0] q30_to_z(input logic [63:0] q30);
    if (FZ <= 30) return IW'((q30 + ((64'd1 << SH_DN) >> 1)) >> SH_DN);
    else          return IW'(q30 << SH_UP);
  endfunction

  localparam logic signed [IW-1:0] PI2    = q30_to_z(64'd1686629713);
  localparam logic signed [IW:0]   RND    = (IW+1)'((1 << GUARD_BITS) >> 1);
  localparam logic signed [IW:0]   SAT_HI = {{(GUARD_BITS+3){1'b0}}, {(WIDTH-1){1'b1}}};
  localparam logic signed [IW:0]   SAT_LO = {{(GUARD_BITS+3){1'b1}}, {(WIDTH-1){1'b0}}};

  function automatic logic [WIDTH-1:0] rnd_sat(input logic signed [IW-1:0] v);
    logic signed [IW:0] t;
    t = ($signed({v[IW-1], v}) + RND) >>> GUARD_BITS;
    if (t > SAT_HI)      return SAT_HI[WIDTH-1:0];
    else if (t < SAT_LO) return SAT_LO[WIDTH-1:0];
    return t[WIDTH-1:0];
  endfunction

`ifdef CORDIC_GAIN_COMP_EN
  localparam int FB     = WIDTH + GUARD_BITS - 1;
  localparam int PW     = IW + FB + 2;
  localparam int SHK_DN = (FB <= 30) ? 30 - FB : 0;
  localparam int SHK_UP = (FB > 30) ? FB - 30 : 0;
  localparam logic [63:0] INVK_Q30 = 64'd652032874;
  localparam logic [63:0] INVK = (FB <= 30) ?
                                 ((INVK_Q30 + ((64'd1 << SHK_DN) >> 1)) >> SHK_DN) :
                                 (INVK_Q30 << SHK_UP);

  function automatic logic signed [IW-1:0] gain_comp(input logic signed [IW-1:0] v);
    return IW'(($signed(PW'(v)) * $signed(PW'(INVK)) + (PW'(1) <<< (FB - 1))) >>> FB);
  endfunction
`endif

  state_t                 r_state;
  logic                   r_mode;
  logic                   r_zero;
  logic [CW-1:0]          r_iter;
  logic signed [IW-1:0]   r_x, r_y, r_z;
  logic [WIDTH-1:0]       r_out_x, r_out_y, r_out_z;
  logic                   r_out_valid;

  logic signed [IW-1:0]   w_xe, w_ye, w_ze;
  logic signed [IW-1:0]   w_x0, w_y0, w_z0;
  logic signed [IW-1:0]   w_xs, w_ys, w_atan;
  logic signed [IW-1:0]   w_x_nx, w_y_nx, w_z_nx;
  logic                   w_d_pos;
  logic signed [IW-1:0]   w_atan_rom [0:ITERATIONS-1];

  for (genvar g = 0; g < ITERATIONS; g++) begin : g_atan
    assign w_atan_rom[g] = q30_to_z(atan_q30(g));
  end

  assign w_xe = $signed(IW'($signed(in_x))) <<< GUARD_BITS;
  assign w_ye = $signed(IW'($signed(in_y))) <<< GUARD_BITS;
  assign w_ze = $signed(IW'($signed(in_z))) <<< GUARD_BITS;

  // Quadrant pre-rotation brings the problem into the +-pi/2 convergence range
  always_comb begin
    w_x0 = w_xe;
    w_y0 = w_ye;
    w_z0 = w_ze;
    if (in_mode) begin
      w_z0 = '0;
      if (w_xe[IW-1]) begin
        if (!w_ye[IW-1]) begin
          w_x0 = w_ye;
          w_y0 = -w_xe;
          w_z0 = PI2;
        end else begin
          w_x0 = -w_ye;
          w_y0 = w_xe;
          w_z0 = -PI2;
        end
      end
    end else if (w_ze > PI2) begin
      w_x0 = -w_ye;
      w_y0 = w_xe;
      w_z0 = w_ze - PI2;
    end else if (w_ze < -PI2) begin
      w_x0 = w_ye;
      w_y0 = -w_xe;
      w_z0 = w_ze + PI2;
    end
  end

  assign w_xs    = r_x >>> r_iter;
  assign w_ys    = r_y >>> r_iter;
  assign w_atan  = w_atan_rom[r_iter];
  assign w_d_pos = r_mode ? r_y[IW-1] : ~r_z[IW-1];
  assign w_x_nx  = w_d_pos ? (r_x - w_ys)   : (r_x + w_ys);
  assign w_y_nx  = w_d_pos ? (r_y + w_xs)   : (r_y - w_xs);
  assign w_z_nx  = w_d_pos ? (r_z - w_atan) : (r_z + w_atan);

  always_ff @(posedge ap_clk or posedge ap_rst) begin
    if (ap_rst) begin
      r_state     <= S_IDLE;
      r_mode      <= 1'b0;
      r_zero      <= 1'b0;
      r_iter      <= '0;
      r_x         <= '0;
      r_y         <= '0;
      r_z         <= '0;
      r_out_x     <= '0;
      r_out_y     <= '0;
      r_out_z     <= '0;
      r_out_valid <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (in_valid) begin
            r_mode  <= in_mode;
            r_zero  <= in_mode && (in_x == '0) && (in_y == '0);
            r_x     <= w_x0;
            r_y     <= w_y0;
            r_z     <= w_z0;
            r_iter  <= '0;
            r_state <= S_ROT;
          end
        end
        S_ROT: begin
          r_x    <= w_x_nx;
          r_y    <= w_y_nx;
          r_z    <= w_z_nx;
          r_iter <= r_iter + 1'b1;
          if (r_iter == LAST) begin
`ifdef CORDIC_GAIN_COMP_EN
            r_state <= S_SCALE;
`else
            // Final micro-rotation feeds the output registers directly to save a cycle
            r_out_x     <= r_zero ? '0 : rnd_sat(w_x_nx);
            r_out_y     <= r_zero ? '0 : rnd_sat(w_y_nx);
            r_out_z     <= r_zero ? '0 : rnd_sat(w_z_nx);
            r_out_valid <= 1'b1;
            r_state     <= S_DONE;
`endif
          end
        end
`ifdef CORDIC_GAIN_COMP_EN
        S_SCALE: begin
          r_out_x     <= r_zero ? '0 : rnd_sat(gain_comp(r_x));
          r_out_y     <= r_zero ? '0 : rnd_sat(gain_comp(r_y));
          r_out_z     <= r_zero ? '0 : rnd_sat(r_z);
          r_out_valid <= 1'b1;
          r_state     <= S_DONE;
        end
`endif
        S_DONE: begin
          if (out_ready) begin
            r_out_valid <= 1'b0;
            r_state     <= S_IDLE;
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign in_ready  = (r_state == S_IDLE) & ~ap_rst;
  assign busy      = (r_state != S_IDLE);
  assign out_valid = r_out_valid;
  assign out_x     = r_out_x;
  assign out_y     = r_out_y;
  assign out_z     = r_out_z;

endmodule

// File: tb/tb_cordic_iter_engine.sv
// Scoreboard bench for cordic_iter_engine: directed vectors, queued expectations, decoupled monitor.
module tb_cordic_iter_engine;
  localparam int W  = 16;
  localparam int IT = 14;
`ifdef CORDIC_GAIN_COMP_EN
  localparam int LAT  = IT + 1;
  localparam int M1   = 16384;
  localparam int M707 = 11585;
  localparam int V707 = 11585;
`else
  localparam int LAT  = IT;
  localparam int M1   = 26981;
  localparam int M707 = 19079;
  localparam int V707 = 19078;
`endif

  logic         ap_clk = 1'b0;
  logic         ap_rst = 1'b1;
  logic         in_valid = 1'b0;
  logic         in_mode = 1'b0;
  logic         out_ready = 1'b1;
  logic [W-1:0] in_x = '0, in_y = '0, in_z = '0;
  logic         in_ready, out_valid, busy;
  logic [W-1:0] out_x, out_y, out_z;

  cordic_iter_engine #(.WIDTH(W), .ITERATIONS(IT), .GUARD_BITS(3)) dut (
    .ap_clk(ap_clk), .ap_rst(ap_rst),
    .in_valid(in_valid), .in_ready(in_ready), .in_mode(in_mode),
    .in_x(in_x), .in_y(in_y), .in_z(in_z),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_x(out_x), .out_y(out_y), .out_z(out_z),
    .busy(busy)
  );

  always #5 ap_clk = ~ap_clk;

  typedef struct {
    string nm;
    int    ex, ey, ez, tol, acc;
  } exp_t;

  exp_t q[$];
  int   checks = 0;
  int   errors = 0;
  int   cyc = 0;
  logic prev_v = 1'b0;

  always @(posedge ap_clk) cyc <= cyc + 1;

  task automatic chk(input string nm, input int act, input int exp, input int tol);
    checks++;
    if (act - exp > tol || exp - act > tol) begin
      errors++;
      $display("FAIL %s: got %0d, expected %0d (tol %0d)", nm, act, exp, tol);
    end
  endtask

  // Monitor: latency on the rising edge of out_valid, values on each output handshake
  always @(negedge ap_clk) begin
    exp_t e;
    if (ap_rst) begin
      prev_v = 1'b0;
    end else begin
      if (out_valid && !prev_v) begin
        if (q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_out_valid: got out_valid=1 with no transaction pending");
        end else begin
          chk({q[0].nm, "_latency"}, cyc - q[0].acc, LAT, 0);
        end
      end
      if (out_valid && out_ready && q.size() > 0) begin
        e = q.pop_front();
        chk({e.nm, "_x"}, int'($signed(out_x)), e.ex, e.tol);
        chk({e.nm, "_y"}, int'($signed(out_y)), e.ey, e.tol);
        chk({e.nm, "_z"}, int'($signed(out_z)), e.ez, e.tol);
      end
      prev_v = out_valid;
    end
  end

  // Called just after a rising edge; returns just after the accepting edge
  task automatic send(input string nm, input logic m, input int x, input int y, input int z,
                      input int ex, input int ey, input int ez, input int tol, input bit push);
    int   t;
    exp_t e;
    t = 0;
    while (!in_ready && t < 200) begin
      @(posedge ap_clk); #1;
      t++;
    end
    if (!in_ready) begin
      checks++;
      errors++;
      $display("FAIL %s_accept_timeout: in_ready stayed 0 for %0d cycles", nm, t);
      return;
    end
    in_valid = 1'b1;
    in_mode  = m;
    in_x     = 16'(x);
    in_y     = 16'(y);
    in_z     = 16'(z);
    @(posedge ap_clk); #1;
    in_valid = 1'b0;
    if (push) begin
      e.nm = nm; e.ex = ex; e.ey = ey; e.ez = ez; e.tol = tol; e.acc = cyc;
      q.push_back(e);
    end
  endtask

  task automatic drain(input string nm);
    int t;
    t = 0;
    while (q.size() > 0 && t < 500) begin
      @(posedge ap_clk); #1;
      t++;
    end
    if (q.size() > 0) begin
      checks++;
      errors++;
      $display("FAIL %s_drain_timeout: %0d results outstanding, expected 0", nm, q.size());
      q.delete();
    end
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached, expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    int t;
    repeat (3) @(posedge ap_clk);
    #1;
    chk("rst_in_ready", int'(in_ready), 0, 0);
    chk("rst_out_valid", int'(out_valid), 0, 0);
    chk("rst_busy", int'(busy), 0, 0);
    chk("rst_out_x", int'($signed(out_x)), 0, 0);
    ap_rst = 1'b0;
    #1;
    chk("rel_in_ready", int'(in_ready), 1, 0);

    send("t1_rot0",   1'b0, 16384, 0, 0,       M1, 0, 0, 4, 1'b1);         drain("t1");
    send("t2_rot45",  1'b0, 16384, 0, 6434,    M707, M707, 0, 8, 1'b1);    drain("t2");
    send("t3_rot135", 1'b0, 16384, 0, 19302,  -M707, M707, 0, 8, 1'b1);    drain("t3");
    send("t3b_rotpi", 1'b0, 16384, 0, -25736, -M1, 0, 0, 8, 1'b1);         drain("t3b");
    send("t4_vec",    1'b1, -8192, -8192, 5000, V707, 0, -19302, 4, 1'b1); drain("t4");
    send("t4_zero",   1'b1, 0, 0, 1234,       0, 0, 0, 0, 1'b1);           drain("t4z");
    send("t4b_vecq2", 1'b1, -16384, 0, 0,     M1, 0, 25736, 8, 1'b1);      drain("t4b");

    // Backpressure: result must hold and extra input pulses must be ignored
    out_ready = 1'b0;
    send("t5_bp", 1'b0, 0, -16384, -6434, -M707, -M707, 0, 8, 1'b1);
    t = 0;
    while (!out_valid && t < 100) begin
      @(posedge ap_clk); #1;
      t++;
    end
    chk("t5_valid_seen", int'(out_valid), 1, 0);
    for (int k = 0; k < 10; k++) begin
      in_valid = (k % 2 == 0);
      in_mode  = 1'b0;
      in_x     = 16'(k * 100);
      in_y     = '0;
      in_z     = '0;
      @(posedge ap_clk); #1;
      chk("t5_hold_valid", int'(out_valid), 1, 0);
      chk("t5_hold_in_ready", int'(in_ready), 0, 0);
      chk("t5_hold_x", int'($signed(out_x)), -M707, 8);
      chk("t5_hold_y", int'($signed(out_y)), -M707, 8);
    end
    in_valid  = 1'b0;
    out_ready = 1'b1;
    @(posedge ap_clk); #1;
    chk("t5_release_valid", int'(out_valid), 0, 0);
    chk("t5_release_in_ready", int'(in_ready), 1, 0);
    chk("t5_release_busy", int'(busy), 0, 0);
    drain("t5");

    // Reset during iteration 5 discards the transaction
    send("t6_abort", 1'b0, 16384, 0, 0, 0, 0, 0, 0, 1'b0);
    repeat (5) @(posedge ap_clk);
    #1;
    chk("t6_busy_before_rst", int'(busy), 1, 0);
    ap_rst = 1'b1;
    #1;
    chk("t6_rst_out_valid", int'(out_valid), 0, 0);
    chk("t6_rst_busy", int'(busy), 0, 0);
    chk("t6_rst_in_ready", int'(in_ready), 0, 0);
    @(posedge ap_clk); #1;
    ap_rst = 1'b0;
    #1;
    chk("t6_rel_in_ready", int'(in_ready), 1, 0);
    send("t6_repeat", 1'b0, 16384, 0, 0, M1, 0, 0, 4, 1'b1);
    drain("t6");

    repeat (3) @(posedge ap_clk);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
